rob_ctrl: RTL and testbench
===========================

// Module: rob_ctrl
// PURPOSE
//   Pointer/control end of the reorder buffer. Allocates ROB tags in order for dispatch (tail side).
//   Reads the head entry through one ROB read port and retires it in order (head side).
//   Each retire writes the register file and clears the ROB cell via one ROB write port.
//   Sits between dispatch/writeback and the rob storage array; it holds no entry payload itself.
// PARAMETERS
//   ROB_DEPTH   32  number of ROB entries; power of two, >= 4
//   DATA_W      32  register value width
//   REG_W       5   architectural register index width
//   ADDR_W      $clog2(ROB_DEPTH)  ROB tag width; derived, not overridable
// PORTS
//   clk          in   1         clock; all state updates on posedge
//   rst          in   1         synchronous reset, ACTIVE-LOW (sampled on posedge clk)
//   alloc_req    in   1         dispatch requests one new tag this cycle
//   alloc_ready  out  1         a tag is available; alloc fires when alloc_req & alloc_ready
//   alloc_tag    out  ADDR_W    tag granted on an alloc fire (= current tail)
//   head_addr    out  ADDR_W    ROB read address (= head pointer); drives a rob rd port
//   head_done    in   1         head entry has completed writeback (combinational read data)
//   head_dst_en  in   1         head entry writes a destination register
//   head_dst     in   REG_W     head entry destination register
//   head_value   in   DATA_W    head entry result value
//   flush        in   1         discard all in-flight entries
//   clr_en       out  1         ROB cell clear strobe (drives a rob wr port, data = 0)
//   clr_addr     out  ADDR_W    ROB cell to clear
//   rf_wr_en     out  1         register file write strobe
//   rf_wr_addr   out  REG_W     register file write index
//   rf_wr_data   out  DATA_W    register file write data
//   busy         out  1         flush sweep in progress
//   count        out  ADDR_W+1  number of occupied entries, 0..ROB_DEPTH
// BEHAVIOUR
//   Reset (rst==0 at posedge): head=tail=0, count=0, state=RUN. All registered outputs are 0:
//     clr_en, clr_addr, rf_wr_*, busy. Reset overrides everything, including mid-FLUSH.
//   States: RUN, FLUSH.
//     RUN --flush--> FLUSH with sweep index=0.
//     FLUSH --index==ROB_DEPTH-1--> RUN with head=tail=0, count=0.
//   alloc_ready = (state==RUN) & (count < ROB_DEPTH) & ~flush.
//     Uses the current count; a same-cycle retire does NOT free a slot for allocation.
//   Alloc fire: alloc_tag = tail; tail <= tail+1, wrapping modulo ROB_DEPTH.
//   Retire condition (RUN, ~flush): count != 0 & head_done.
//     Head-side reads are combinational from head_addr. At most one retire per cycle.
//   On retire, head <= head+1 (wraps). Registered 1-cycle-later outputs:
//     clr_en=1, clr_addr=old head.
//     rf_wr_en = head_dst_en & (head_dst != 0); rf_wr_addr=head_dst; rf_wr_data=head_value.
//   Strobes are single-cycle pulses, 0 in any cycle without a retire; the *_addr/_data hold their last value.
//   count: +1 on alloc only, -1 on retire only, unchanged on both; never exceeds ROB_DEPTH or drops below 0.
//   flush is asserted in RUN:
//     it takes priority over a same-cycle alloc (alloc_ready=0) and a same-cycle retire (no retire).
//     next cycle: busy=1, state=FLUSH.
//   FLUSH: clr_en=1, clr_addr=index on each cycle, index 0..ROB_DEPTH-1, one per cycle.
//     rf_wr_en=0. alloc_ready=0. flush input ignored.
//     busy falls in the cycle after the last clear.
//   Total flush penalty: ROB_DEPTH cycles with busy=1.
// TESTING
//   1. Reset: hold rst=0 two cycles -> count=0, alloc_ready=1, head_addr=0, all strobes 0.
//   2. Alloc 3 with head_done=0 -> alloc_tag 0,1,2 on successive fires; count=3; no rf_wr_en.
//   3. head_done=1, dst_en=1, dst=5, value=0xDEAD at head 0 -> next cycle:
//        rf_wr_en=1, addr=5, data=0xDEAD; clr_en=1, clr_addr=0; head_addr=1; count=2.
//   4. Fill to 32 entries -> alloc_ready=0 and alloc_req ignored.
//      Simultaneous alloc+retire at count=31 -> count stays 31, tail and head both advance.
//      Wrap: tail 31 -> 0.
//   5. Retire with dst=0 or dst_en=0 -> rf_wr_en=0 but clr_en=1.
//   6. flush with alloc_req=1 and head_done=1 at count=4 -> no alloc, no retire.
//      busy=1 for 32 cycles with clr_addr 0..31; then head=tail=count=0 and alloc_ready=1.
//      Repeat with rst=0 mid-flush -> immediate RUN, busy=0.

Source files
------------

// File: rtl/rob_ctrl_if.sv
// Bundle between rob_ctrl and its neighbours: dispatch, the ROB storage read/write ports and the register file.
// The master side is the controller; the slave side is the surrounding pipeline and storage.
interface rob_ctrl_if #(
  parameter int ROB_DEPTH = 32,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
);
  localparam int ADDR_W = $clog2(ROB_DEPTH);

  // dispatch side
  logic              alloc_req;
  logic              alloc_ready;
  logic [ADDR_W-1:0] alloc_tag;

  // head read port
  logic [ADDR_W-1:0] head_addr;
  logic              head_done;
  logic              head_dst_en;
  logic [REG_W-1:0]  head_dst;
  logic [DATA_W-1:0] head_value;

  // control and status
  logic              flush;
  logic              busy;
  logic [ADDR_W:0]   count;

  // ROB clear port
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  // register file write port
  logic              rf_wr_en;
  logic [REG_W-1:0]  rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  modport master (
    input  alloc_req, head_done, head_dst_en, head_dst, head_value, flush,
    output alloc_ready, alloc_tag, head_addr, busy, count,
           clr_en, clr_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output alloc_req, head_done, head_dst_en, head_dst, head_value, flush,
    input  alloc_ready, alloc_tag, head_addr, busy, count,
           clr_en, clr_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/control: in-order tag allocation at the tail, in-order retire at the head,
// and a one-entry-per-cycle clearing sweep on flush. No entry payload is stored here.
module rob_ctrl #(
  parameter int ROB_DEPTH = 32,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic          clk,
  input  logic          rst,
  rob_ctrl_if.master    bus
);
  localparam int ADDR_W = $clog2(ROB_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(ROB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ROB_DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              clr_en_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              rf_wr_en_q;
  logic [REG_W-1:0]  rf_wr_addr_q;
  logic [DATA_W-1:0] rf_wr_data_q;

  logic              alloc_ready_d;
  logic              alloc_fire_d;
  logic              retire_d;
  logic [ADDR_W-1:0] head_d;
  logic [ADDR_W-1:0] tail_d;
  logic [ADDR_W:0]   count_d;

  // Readiness looks only at the current count, so a same-cycle retire never
  // frees the slot for the allocation happening alongside it.
  always_comb begin
    alloc_ready_d = (state_q == RUN) && (count_q < DEPTH_CNT) && !bus.flush;
    alloc_fire_d  = bus.alloc_req && alloc_ready_d;
    retire_d      = (state_q == RUN) && !bus.flush && (count_q != '0) && bus.head_done;

    head_d  = retire_d     ? head_q + ADDR_W'(1) : head_q;
    tail_d  = alloc_fire_d ? tail_q + ADDR_W'(1) : tail_q;
    count_d = count_q;
    if (alloc_fire_d && !retire_d) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (retire_d && !alloc_fire_d) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      clr_en_q     <= 1'b0;
      clr_addr_q   <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.flush) begin
            state_q    <= FLUSH;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            clr_en_q   <= 1'b1;
            clr_addr_q <= '0;
            rf_wr_en_q <= 1'b0;
          end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            clr_en_q   <= retire_d;
            rf_wr_en_q <= retire_d && bus.head_dst_en && (bus.head_dst != '0);
            if (retire_d) begin
              clr_addr_q   <= head_q;
              rf_wr_addr_q <= bus.head_dst;
              rf_wr_data_q <= bus.head_value;
            end
          end
        end

        FLUSH: begin
          rf_wr_en_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q  <= RUN;
            busy_q   <= 1'b0;
            clr_en_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
          end else begin
            idx_q      <= idx_q + ADDR_W'(1);
            clr_en_q   <= 1'b1;
            clr_addr_q <= idx_q + ADDR_W'(1);
          end
        end

        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.alloc_ready = alloc_ready_d;
  assign bus.alloc_tag   = tail_q;
  assign bus.head_addr   = head_q;
  assign bus.busy        = busy_q;
  assign bus.count       = count_q;
  assign bus.clr_en      = clr_en_q;
  assign bus.clr_addr    = clr_addr_q;
  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_wr_addr  = rf_wr_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: a vector table for reset/alloc/retire, then hand sequences
// for fill/wrap, simultaneous alloc+retire, the flush sweep and reset during a sweep.
module tb_rob_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  rob_ctrl_if bus ();

  rob_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        areq;
    logic        hd;
    logic        den;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        fl;
    logic        ardy;
    logic [4:0]  tag;
    logic [4:0]  haddr;
    logic        clr;
    logic [4:0]  caddr;
    logic        rfen;
    logic [4:0]  rfa;
    logic [31:0] rfd;
    logic        busy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic areq, input logic hd, input logic den,
                       input logic [4:0] dst, input logic [31:0] val, input logic fl);
    rst             = r;
    bus.alloc_req   = areq;
    bus.head_done   = hd;
    bus.head_dst_en = den;
    bus.head_dst    = dst;
    bus.head_value  = val;
    bus.flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //          rst areq hd den dst   val            fl | ardy tag haddr clr caddr rfen rfa rfd           busy cnt
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd0,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,     1'b0,6'd0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd0,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,     1'b0,6'd0};
    vecs[2] = '{1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd1,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,     1'b0,6'd1};
    vecs[3] = '{1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd2,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,     1'b0,6'd2};
    vecs[4] = '{1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd3,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,     1'b0,6'd3};
    vecs[5] = '{1'b1,1'b0,1'b1,1'b1,5'd5,32'hDEAD,   1'b0, 1'b1,5'd3,5'd1,1'b1,5'd0,1'b1,5'd5,32'hDEAD,  1'b0,6'd2};
    vecs[6] = '{1'b1,1'b0,1'b1,1'b0,5'd7,32'hBEEF,   1'b0, 1'b1,5'd3,5'd2,1'b1,5'd1,1'b0,5'd7,32'hBEEF,  1'b0,6'd1};
    vecs[7] = '{1'b1,1'b0,1'b1,1'b1,5'd0,32'h1234,   1'b0, 1'b1,5'd3,5'd3,1'b1,5'd2,1'b0,5'd0,32'h1234,  1'b0,6'd0};
    vecs[8] = '{1'b1,1'b0,1'b1,1'b1,5'd3,32'h55,     1'b0, 1'b1,5'd3,5'd3,1'b0,5'd2,1'b0,5'd0,32'h1234,  1'b0,6'd0};
    vecs[9] = '{1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,      1'b0, 1'b1,5'd3,5'd3,1'b0,5'd2,1'b0,5'd0,32'h1234,  1'b0,6'd0};

    drive(vecs[0].rst, vecs[0].areq, vecs[0].hd, vecs[0].den, vecs[0].dst, vecs[0].val, vecs[0].fl);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("v%0d_ardy", i),  32'(bus.alloc_ready), 32'(vecs[i].ardy));
      chk($sformatf("v%0d_tag", i),   32'(bus.alloc_tag),   32'(vecs[i].tag));
      chk($sformatf("v%0d_haddr", i), 32'(bus.head_addr),   32'(vecs[i].haddr));
      chk($sformatf("v%0d_clr", i),   32'(bus.clr_en),      32'(vecs[i].clr));
      chk($sformatf("v%0d_caddr", i), 32'(bus.clr_addr),    32'(vecs[i].caddr));
      chk($sformatf("v%0d_rfen", i),  32'(bus.rf_wr_en),    32'(vecs[i].rfen));
      chk($sformatf("v%0d_rfa", i),   32'(bus.rf_wr_addr),  32'(vecs[i].rfa));
      chk($sformatf("v%0d_rfd", i),   bus.rf_wr_data,       vecs[i].rfd);
      chk($sformatf("v%0d_busy", i),  32'(bus.busy),        32'(vecs[i].busy));
      chk($sformatf("v%0d_cnt", i),   32'(bus.count),       32'(vecs[i].cnt));
      $display("vec %0d: cnt=%0d head=%0d tag=%0d clr=%0b rfen=%0b", i, bus.count, bus.head_addr,
               bus.alloc_tag, bus.clr_en, bus.rf_wr_en);
      if (i < 9) drive(vecs[i+1].rst, vecs[i+1].areq, vecs[i+1].hd, vecs[i+1].den,
                       vecs[i+1].dst, vecs[i+1].val, vecs[i+1].fl);
    end

    // fill from head=tail=3 to full; tags wrap 31 -> 0
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      #1;
      chk("fill_tag", 32'(bus.alloc_tag), 32'((3 + i) % 32));
      step();
      chk("fill_cnt", 32'(bus.count), 32'(i + 1));
    end
    $display("fill: cnt=%0d ardy=%0b", bus.count, bus.alloc_ready);
    chk("full_ardy", 32'(bus.alloc_ready), 32'd0);
    step();
    chk("full_cnt", 32'(bus.count), 32'd32);
    chk("full_tag", 32'(bus.alloc_tag), 32'd3);

    // retire at full while alloc_req held: only retire happens
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    $display("retire@full: cnt=%0d head=%0d", bus.count, bus.head_addr);
    chk("rf_cnt", 32'(bus.count), 32'd31);
    chk("rf_head", 32'(bus.head_addr), 32'd4);
    chk("rf_caddr", 32'(bus.clr_addr), 32'd3);
    chk("rf_ardy", 32'(bus.alloc_ready), 32'd1);
    // alloc + retire together at count 31
    step();
    $display("alloc+retire: cnt=%0d head=%0d tag=%0d", bus.count, bus.head_addr, bus.alloc_tag);
    chk("ar_cnt", 32'(bus.count), 32'd31);
    chk("ar_head", 32'(bus.head_addr), 32'd5);
    chk("ar_tag", 32'(bus.alloc_tag), 32'd4);
    chk("ar_caddr", 32'(bus.clr_addr), 32'd4);

    // flush at count 4 with alloc_req and head_done asserted
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (4) step();
    chk("pre_cnt", 32'(bus.count), 32'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h77, 1'b1);
    #1;
    chk("fl_ardy_comb", 32'(bus.alloc_ready), 32'd0);
    step();
    $display("flush start: busy=%0b cnt=%0d clr_addr=%0d", bus.busy, bus.count, bus.clr_addr);
    chk("fl_busy0", 32'(bus.busy), 32'd1);
    chk("fl_clr0", 32'(bus.clr_en), 32'd1);
    chk("fl_caddr0", 32'(bus.clr_addr), 32'd0);
    chk("fl_rfen", 32'(bus.rf_wr_en), 32'd0);
    chk("fl_cnt", 32'(bus.count), 32'd4);
    chk("fl_tag", 32'(bus.alloc_tag), 32'd4);
    chk("fl_head", 32'(bus.head_addr), 32'd0);
    for (int i = 1; i < 32; i++) begin
      step();
      chk("sw_busy", 32'(bus.busy), 32'd1);
      chk("sw_clr", 32'(bus.clr_en), 32'd1);
      chk("sw_caddr", 32'(bus.clr_addr), 32'(i));
      chk("sw_ardy", 32'(bus.alloc_ready), 32'd0);
      chk("sw_rfen", 32'(bus.rf_wr_en), 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    $display("flush end: busy=%0b cnt=%0d head=%0d tag=%0d", bus.busy, bus.count, bus.head_addr, bus.alloc_tag);
    chk("fe_busy", 32'(bus.busy), 32'd0);
    chk("fe_clr", 32'(bus.clr_en), 32'd0);
    chk("fe_cnt", 32'(bus.count), 32'd0);
    chk("fe_head", 32'(bus.head_addr), 32'd0);
    chk("fe_tag", 32'(bus.alloc_tag), 32'd0);
    chk("fe_ardy", 32'(bus.alloc_ready), 32'd1);

    // reset in the middle of a sweep
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    step();
    chk("mr_busy1", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (3) step();
    chk("mr_caddr", 32'(bus.clr_addr), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    $display("mid-flush reset: busy=%0b cnt=%0d clr=%0b", bus.busy, bus.count, bus.clr_en);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_clr", 32'(bus.clr_en), 32'd0);
    chk("mr_caddr0", 32'(bus.clr_addr), 32'd0);
    chk("mr_cnt", 32'(bus.count), 32'd0);
    chk("mr_tag", 32'(bus.alloc_tag), 32'd0);
    chk("mr_ardy", 32'(bus.alloc_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    chk("mr_run_cnt", 32'(bus.count), 32'd1);
    chk("mr_run_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
